// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator; hsync/vsync/de delayed SYNC_DELAY enabled cycles, x/y/tp_rgb zero latency, pulses registered.
// No backpressure: pix_ce=0 freezes all state. Optional RGB332 test pattern under VGA_TIMING_TEST_PATTERN_EN.
`timescale 1ns/1ps
module vga_timing_gen #(
    parameter int H_SYNC     = 128,
    parameter int H_BACK     = 88,
    parameter int H_ACTIVE   = 800,
    parameter int H_FRONT    = 40,
    parameter int V_SYNC     = 4,
    parameter int V_BACK     = 23,
    parameter int V_ACTIVE   = 600,
    parameter int V_FRONT    = 1,
    parameter int SYNC_DELAY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_ce,
    output logic [10:0] count_h,
    output logic [9:0]  count_v,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        frame_start,
    output logic        vblank_tick,
    output logic [7:0]  tp_rgb
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_SYNC_END = 11'(H_SYNC);
    localparam logic [10:0] H_ACT_BEG  = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_ACT_END  = 11'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_SYNC_END = 10'(V_SYNC);
    localparam logic [9:0]  V_ACT_BEG  = 10'(V_SYNC + V_BACK);
    localparam logic [9:0]  V_ACT_END  = 10'(V_SYNC + V_BACK + V_ACTIVE);

    if (H_TOTAL > 2047 || V_TOTAL > 1023 || H_ACTIVE > 1024 || V_ACTIVE > 1024 ||
        SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_bad_params
        $error("vga_timing_gen: illegal timing parameter set");
    end

    logic [10:0] count_h_q, count_h_d;
    logic [9:0]  count_v_q, count_v_d;
    logic        frame_start_q, frame_start_d;
    logic        vblank_tick_q, vblank_tick_d;
    logic        h_wrap, v_wrap;

    always_comb begin
        h_wrap    = (count_h_q == H_LAST);
        v_wrap    = (count_v_q == V_LAST);
        count_h_d = count_h_q;
        count_v_d = count_v_q;
        if (pix_ce) begin
            if (h_wrap) begin
                count_h_d = '0;
                count_v_d = v_wrap ? '0 : count_v_q + 10'd1;
            end else begin
                count_h_d = count_h_q + 11'd1;
            end
        end
        // Pulses mark the edge that loads the target position, so they need pix_ce.
        frame_start_d = pix_ce && (count_h_d == '0) && (count_v_d == '0);
        vblank_tick_d = pix_ce && (count_h_d == '0) && (count_v_d == V_ACT_END);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_h_q     <= '0;
            count_v_q     <= '0;
            frame_start_q <= 1'b0;
            vblank_tick_q <= 1'b0;
        end else begin
            count_h_q     <= count_h_d;
            count_v_q     <= count_v_d;
            frame_start_q <= frame_start_d;
            vblank_tick_q <= vblank_tick_d;
        end
    end

    logic hs_raw, vs_raw, de_raw, h_act, v_act;

    assign hs_raw = (count_h_q >= H_SYNC_END);
    assign vs_raw = (count_v_q >= V_SYNC_END);
    assign h_act  = (count_h_q >= H_ACT_BEG) && (count_h_q < H_ACT_END);
    assign v_act  = (count_v_q >= V_ACT_BEG) && (count_v_q < V_ACT_END);
    assign de_raw = h_act && v_act;

    assign x = de_raw ? 10'(count_h_q - H_ACT_BEG) : '0;
    assign y = de_raw ? (count_v_q - V_ACT_BEG) : '0;

    if (SYNC_DELAY == 0) begin : g_no_delay
        assign hsync = hs_raw;
        assign vsync = vs_raw;
        assign de    = de_raw;
    end else begin : g_delay
        logic [SYNC_DELAY-1:0] hs_pipe_q, vs_pipe_q, de_pipe_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                hs_pipe_q <= '1;
                vs_pipe_q <= '1;
                de_pipe_q <= '0;
            end else if (pix_ce) begin
                hs_pipe_q <= SYNC_DELAY'({hs_pipe_q, hs_raw});
                vs_pipe_q <= SYNC_DELAY'({vs_pipe_q, vs_raw});
                de_pipe_q <= SYNC_DELAY'({de_pipe_q, de_raw});
            end
        end

        assign hsync = hs_pipe_q[SYNC_DELAY-1];
        assign vsync = vs_pipe_q[SYNC_DELAY-1];
        assign de    = de_pipe_q[SYNC_DELAY-1];
    end

`ifdef VGA_TIMING_TEST_PATTERN_EN
    localparam int         BAR_W  = 100;
    localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

    logic [2:0] bar_idx;
    logic [7:0] tp_rgb_d;

    always_comb begin
        // Threshold compares give x/100 without a divider; columns past 799 stay in the last bar.
        bar_idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (x >= 10'(i * BAR_W)) bar_idx = 3'(i);
        end
        tp_rgb_d = 8'h00;
        if (de_raw) begin
            if (x == '0 || x == X_LAST || y == '0 || y == Y_LAST) begin
                tp_rgb_d = 8'hFF;
            end else begin
                case (bar_idx)
                    3'd0:    tp_rgb_d = 8'hFF;
                    3'd1:    tp_rgb_d = 8'hFC;
                    3'd2:    tp_rgb_d = 8'h1F;
                    3'd3:    tp_rgb_d = 8'h1C;
                    3'd4:    tp_rgb_d = 8'hE3;
                    3'd5:    tp_rgb_d = 8'hE0;
                    3'd6:    tp_rgb_d = 8'h03;
                    default: tp_rgb_d = 8'h00;
                endcase
            end
        end
    end

    assign tp_rgb = tp_rgb_d;
`else
    assign tp_rgb = 8'h00;
`endif

    assign count_h     = count_h_q;
    assign count_v     = count_v_q;
    assign frame_start = frame_start_q;
    assign vblank_tick = vblank_tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default instance plus two reduced rasters (SYNC_DELAY 4 and 0),
// scoreboarded against a model that derives every output from the count of enabled edges.
`timescale 1ns/1ps
module tb_vga_timing_gen;

    localparam int NI = 3;
    localparam int P_HSY [NI] = '{128, 8, 5};
    localparam int P_HBK [NI] = '{88,  6, 3};
    localparam int P_HAC [NI] = '{800, 20, 12};
    localparam int P_HFP [NI] = '{40,  4, 2};
    localparam int P_VSY [NI] = '{4,   2, 1};
    localparam int P_VBK [NI] = '{23,  3, 2};
    localparam int P_VAC [NI] = '{600, 10, 5};
    localparam int P_VFP [NI] = '{1,   1, 2};
    localparam int P_DLY [NI] = '{1,   4, 0};

    typedef struct packed {
        logic [10:0] ch;
        logic [9:0]  cv;
        logic        hs;
        logic        vs;
        logic        de;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        fs;
        logic        vb;
        logic [7:0]  tp;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    logic pix_ce;

    logic [10:0] ch [NI];
    logic [9:0]  cv [NI];
    logic        hs [NI];
    logic        vs [NI];
    logic        de [NI];
    logic [9:0]  xo [NI];
    logic [9:0]  yo [NI];
    logic        fs [NI];
    logic        vb [NI];
    logic [7:0]  tp [NI];

    always #5 clk = ~clk;

    vga_timing_gen u_dflt (
        .clk(clk), .rst(rst), .pix_ce(pix_ce),
        .count_h(ch[0]), .count_v(cv[0]), .hsync(hs[0]), .vsync(vs[0]), .de(de[0]),
        .x(xo[0]), .y(yo[0]), .frame_start(fs[0]), .vblank_tick(vb[0]), .tp_rgb(tp[0])
    );

    vga_timing_gen #(
        .H_SYNC(P_HSY[1]), .H_BACK(P_HBK[1]), .H_ACTIVE(P_HAC[1]), .H_FRONT(P_HFP[1]),
        .V_SYNC(P_VSY[1]), .V_BACK(P_VBK[1]), .V_ACTIVE(P_VAC[1]), .V_FRONT(P_VFP[1]),
        .SYNC_DELAY(P_DLY[1])
    ) u_d4 (
        .clk(clk), .rst(rst), .pix_ce(pix_ce),
        .count_h(ch[1]), .count_v(cv[1]), .hsync(hs[1]), .vsync(vs[1]), .de(de[1]),
        .x(xo[1]), .y(yo[1]), .frame_start(fs[1]), .vblank_tick(vb[1]), .tp_rgb(tp[1])
    );

    vga_timing_gen #(
        .H_SYNC(P_HSY[2]), .H_BACK(P_HBK[2]), .H_ACTIVE(P_HAC[2]), .H_FRONT(P_HFP[2]),
        .V_SYNC(P_VSY[2]), .V_BACK(P_VBK[2]), .V_ACTIVE(P_VAC[2]), .V_FRONT(P_VFP[2]),
        .SYNC_DELAY(P_DLY[2])
    ) u_d0 (
        .clk(clk), .rst(rst), .pix_ce(pix_ce),
        .count_h(ch[2]), .count_v(cv[2]), .hsync(hs[2]), .vsync(vs[2]), .de(de[2]),
        .x(xo[2]), .y(yo[2]), .frame_start(fs[2]), .vblank_tick(vb[2]), .tp_rgb(tp[2])
    );

    obs_t   exp_q   [NI][$];
    obs_t   async_q [NI][$];
    longint n_en    [NI];
    int     n_checks = 0;
    int     n_pass   = 0;
    int     n_fail   = 0;
    bit     stim_done = 1'b0;
    bit     summary_done = 1'b0;
    int     act_fs [NI], exp_fs [NI], act_vb [NI], exp_vb [NI];
    int     act_org [NI], exp_org [NI], act_last [NI], exp_last [NI];

    // ---------------- reference model ----------------
    function automatic bit in_active(int k, int h, int v);
        int h0 = P_HSY[k] + P_HBK[k];
        int v0 = P_VSY[k] + P_VBK[k];
        return (h >= h0) && (h < h0 + P_HAC[k]) && (v >= v0) && (v < v0 + P_VAC[k]);
    endfunction

    function automatic logic [7:0] pattern(int k, int px, int py);
`ifdef VGA_TIMING_TEST_PATTERN_EN
        int bar;
        if (px == 0 || px == P_HAC[k] - 1 || py == 0 || py == P_VAC[k] - 1) return 8'hFF;
        bar = px / 100;
        if (bar > 7) bar = 7;
        case (bar)
            0: return 8'hFF;
            1: return 8'hFC;
            2: return 8'h1F;
            3: return 8'h1C;
            4: return 8'hE3;
            5: return 8'hE0;
            6: return 8'h03;
            default: return 8'h00;
        endcase
`else
        return (px < 0 || py < 0 || k < 0) ? 8'h01 : 8'h00;
`endif
    endfunction

    // Expected outputs after n enabled edges since reset; pulse_en says the last edge advanced.
    function automatic obs_t model(int k, longint n, bit pulse_en);
        obs_t   o;
        int     ht = P_HSY[k] + P_HBK[k] + P_HAC[k] + P_HFP[k];
        int     vt = P_VSY[k] + P_VBK[k] + P_VAC[k] + P_VFP[k];
        longint ft = longint'(ht) * vt;
        longint f, m;
        int     h, v, hd, vd;
        o = '0;
        f = n % ft;
        h = int'(f % ht);
        v = int'(f / ht);
        o.ch = 11'(h);
        o.cv = 10'(v);
        if (in_active(k, h, v)) begin
            o.x  = 10'(h - P_HSY[k] - P_HBK[k]);
            o.y  = 10'(v - P_VSY[k] - P_VBK[k]);
            o.tp = pattern(k, int'(o.x), int'(o.y));
        end
        if (n >= P_DLY[k]) begin
            m  = (n - P_DLY[k]) % ft;
            hd = int'(m % ht);
            vd = int'(m / ht);
            o.hs = (hd >= P_HSY[k]);
            o.vs = (vd >= P_VSY[k]);
            o.de = in_active(k, hd, vd);
        end else begin
            o.hs = 1'b1;
            o.vs = 1'b1;
            o.de = 1'b0;
        end
        o.fs = pulse_en && (f == 0);
        o.vb = pulse_en && (f == longint'(P_VSY[k] + P_VBK[k] + P_VAC[k]) * ht);
        return o;
    endfunction

    function automatic obs_t actual(int k);
        obs_t o;
        o.ch = ch[k]; o.cv = cv[k]; o.hs = hs[k]; o.vs = vs[k]; o.de = de[k];
        o.x  = xo[k]; o.y  = yo[k]; o.fs = fs[k]; o.vb = vb[k]; o.tp = tp[k];
        return o;
    endfunction

    function automatic bit origin_hit(int k, obs_t o);
        return o.ch == 11'(P_HSY[k] + P_HBK[k]) && o.cv == 10'(P_VSY[k] + P_VBK[k]) &&
               o.x == 10'd0 && o.y == 10'd0;
    endfunction

    function automatic bit last_hit(int k, obs_t o);
        return o.ch == 11'(P_HSY[k] + P_HBK[k] + P_HAC[k] - 1) &&
               o.cv == 10'(P_VSY[k] + P_VBK[k] + P_VAC[k] - 1) &&
               o.x == 10'(P_HAC[k] - 1) && o.y == 10'(P_VAC[k] - 1);
    endfunction

    // ---------------- checking ----------------
    task automatic finish_run();
        if (!summary_done) begin
            summary_done = 1'b1;
            $display("%0d/%0d checks passed", n_pass, n_checks);
            $finish;
        end
    endtask

    task automatic chk(input string nm, input int k, input logic [31:0] a, input logic [31:0] e);
        n_checks++;
        if (a === e) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s inst%0d t=%0t: got 0x%0h, want 0x%0h", nm, k, $time, a, e);
            if (n_fail >= 50) finish_run();
        end
    endtask

    task automatic compare_obs(input int k, input obs_t a, input obs_t e);
        chk("count_h", k, 32'(a.ch), 32'(e.ch));
        chk("count_v", k, 32'(a.cv), 32'(e.cv));
        chk("hsync", k, 32'(a.hs), 32'(e.hs));
        chk("vsync", k, 32'(a.vs), 32'(e.vs));
        chk("de", k, 32'(a.de), 32'(e.de));
        chk("x", k, 32'(a.x), 32'(e.x));
        chk("y", k, 32'(a.y), 32'(e.y));
        chk("frame_start", k, 32'(a.fs), 32'(e.fs));
        chk("vblank_tick", k, 32'(a.vb), 32'(e.vb));
        chk("tp_rgb", k, 32'(a.tp), 32'(e.tp));
    endtask

    initial begin : monitor
        obs_t a, e;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < NI; k++) begin
                if (exp_q[k].size() == 0) begin
                    if (!stim_done) chk("scoreboard_underflow", k, 32'd0, 32'd1);
                end else begin
                    e = exp_q[k].pop_front();
                    a = actual(k);
                    compare_obs(k, a, e);
                    act_fs[k]   += int'(a.fs);
                    exp_fs[k]   += int'(e.fs);
                    act_vb[k]   += int'(a.vb);
                    exp_vb[k]   += int'(e.vb);
                    act_org[k]  += int'(origin_hit(k, a));
                    exp_org[k]  += int'(origin_hit(k, e));
                    act_last[k] += int'(last_hit(k, a));
                    exp_last[k] += int'(last_hit(k, e));
                end
            end
        end
    end

    initial begin : async_monitor
        obs_t e;
        forever begin
            @(posedge rst);
            #1;
            for (int k = 0; k < NI; k++) begin
                if (async_q[k].size() != 0) begin
                    e = async_q[k].pop_front();
                    compare_obs(k, actual(k), e);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit ce_next, input bit rst_next);
        bit pe;
        @(posedge clk);
        for (int k = 0; k < NI; k++) begin
            pe = 1'b0;
            if (rst) begin
                n_en[k] = 0;
            end else if (pix_ce) begin
                n_en[k]++;
                pe = 1'b1;
            end
            exp_q[k].push_back(model(k, n_en[k], pe));
        end
        #2;
        if (rst_next && !rst) begin
            for (int k = 0; k < NI; k++) async_q[k].push_back(model(k, 0, 1'b0));
        end
        pix_ce = ce_next;
        rst    = rst_next;
    endtask

    initial begin : stimulus
        rst    = 1'b1;
        pix_ce = 1'b1;
        for (int k = 0; k < NI; k++) begin
            n_en[k] = 0;
            act_fs[k] = 0; exp_fs[k] = 0; act_vb[k] = 0; exp_vb[k] = 0;
            act_org[k] = 0; exp_org[k] = 0; act_last[k] = 0; exp_last[k] = 0;
        end
        repeat (2) step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        // Continuous enable long enough for the default raster to pass its first active pixel.
        repeat (29 * 1056) step(1'b1, 1'b0);
        repeat (6000) step(1'($urandom_range(0, 1)), 1'b0);
        step(1'($urandom_range(0, 1)), 1'b1);
        repeat (2) step(1'($urandom_range(0, 1)), 1'b1);
        step(1'($urandom_range(0, 1)), 1'b0);
        repeat (4000) step(1'($urandom_range(0, 1)), 1'b0);
        repeat (2000) step(1'b1, 1'b0);
        stim_done = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        for (int k = 0; k < NI; k++) begin
            chk("queue_drained", k, 32'(exp_q[k].size()), 32'd0);
            chk("frame_start_count", k, 32'(act_fs[k]), 32'(exp_fs[k]));
            chk("vblank_tick_count", k, 32'(act_vb[k]), 32'(exp_vb[k]));
            chk("first_active_pixel_count", k, 32'(act_org[k]), 32'(exp_org[k]));
            chk("last_active_pixel_count", k, 32'(act_last[k]), 32'(exp_last[k]));
        end
        chk("default_raster_reached_active", 0, 32'(exp_org[0] >= 1), 32'd1);
        chk("small_raster_frames_seen", 1, 32'(exp_fs[1] >= 2), 32'd1);
        finish_run();
    end

endmodule
